// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and types for the SHAKE core.
//   w / w_byte_size / w_byte_width : lane width in bits, bytes, and log2(bytes).
//   SHAKE128_RATE_WORDS / SHAKE256_RATE_WORDS : rate in lanes for each variant.
//   squeeze_state_t : state encoding of the squeeze output FSM.
package keccak_pkg;
  localparam int w            = 64;
  localparam int w_byte_size  = w / 8;
  localparam int w_byte_width = $clog2(w_byte_size);

  localparam int SHAKE128_RATE_WORDS = 21;
  localparam int SHAKE256_RATE_WORDS = 17;

  typedef enum logic [2:0] {
    SQ_IDLE       = 3'd0,
    SQ_WAIT_BLOCK = 3'd1,
    SQ_EMIT       = 3'd2,
    SQ_REQUEST    = 3'd3,
    SQ_DONE       = 3'd4
  } squeeze_state_t;
endpackage

// File: rtl/byte_valid_mask.sv
// byte_valid_mask: combinational valid-byte-count to keep-mask converter.
//   i_count : number of valid bytes (0..w_byte_size)
//   o_mask  : one bit per byte, bit b set when byte b is kept. Valid bytes are
//             the most-significant ones, so count k sets bits
//             w_byte_size-1 down to w_byte_size-k.
module byte_valid_mask
  import keccak_pkg::*;
(
  input  logic [w_byte_width:0]  i_count,
  output logic [w_byte_size-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int b = 0; b < w_byte_size; b++) begin
      o_mask[b] = ((b + int'(i_count)) >= w_byte_size);
    end
  end

endmodule

// File: rtl/squeeze_output_unit.sv
// squeeze_output_unit: streams the rate part of the Keccak state one lane at a
// time, truncated to a byte-exact output length, and asks for further
// permutations when one rate block is not enough.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a squeeze (IDLE only); out_len_bytes captured
//   block_valid/ready : permutation result available / unit waiting for one
//   word_idx          : lane index being read; state_word is that lane
//   perm_request      : one-cycle pulse requesting another permutation
//   dout*             : output stream; dout_valid_bytes counts MSB-first bytes
//   done              : one-cycle pulse when the squeeze completes
//   dbg_state         : current FSM state, for observation only
//
// Handshake: a word transfers on every rising edge where dout_valid and
// dout_ready are both high; while dout_valid is high and dout_ready is low,
// dout, dout_valid_bytes, dout_last and word_idx hold unchanged, and
// dout_valid never drops until the word is taken.
module squeeze_output_unit
  import keccak_pkg::*;
#(
  parameter int RATE_WORDS = 21,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [LEN_WIDTH-1:0]                         out_len_bytes,
  input  logic                                         block_valid,
  output logic                                         block_ready,
  output logic [((RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1)-1:0] word_idx,
  input  logic [w-1:0]                                 state_word,
  output logic                                         perm_request,
  output logic [w-1:0]                                 dout,
  output logic [w_byte_width:0]                        dout_valid_bytes,
  output logic                                         dout_last,
  output logic                                         dout_valid,
  input  logic                                         dout_ready,
  output logic                                         done,
  output logic [2:0]                                   dbg_state
);

  localparam int IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam int VB_W  = w_byte_width + 1;

  squeeze_state_t       r_state;
  squeeze_state_t       w_next;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [IDX_W-1:0]     r_word_idx;

  logic [VB_W-1:0]        w_vbytes;
  logic                   w_last;
  logic [w_byte_size-1:0] w_mask;
  logic [w-1:0]           w_dout;
  logic                   w_idx_at_end;
  logic                   w_accept;

  // Byte count and last flag are forced to zero outside EMIT so the whole
  // output bus (including dout via the mask) reads 0 when nothing is offered.
  always_comb begin
    w_vbytes = '0;
    w_last   = 1'b0;
    if (r_state == SQ_EMIT) begin
      if (r_remaining >= LEN_WIDTH'(w_byte_size)) begin
        w_vbytes = VB_W'(w_byte_size);
      end else begin
        w_vbytes = r_remaining[VB_W-1:0];
      end
      w_last = (r_remaining <= LEN_WIDTH'(w_byte_size));
    end
  end

  byte_valid_mask u_mask (
    .i_count (w_vbytes),
    .o_mask  (w_mask)
  );

  always_comb begin
    w_dout = '0;
    for (int b = 0; b < w_byte_size; b++) begin
      if (w_mask[b]) begin
        w_dout[8*b +: 8] = state_word[8*b +: 8];
      end
    end
  end

  assign w_idx_at_end = (r_word_idx == IDX_W'(RATE_WORDS - 1));
  assign w_accept     = (r_state == SQ_EMIT) && dout_ready;

  always_comb begin
    w_next       = r_state;
    block_ready  = 1'b0;
    perm_request = 1'b0;
    done         = 1'b0;
    dout_valid   = 1'b0;
    case (r_state)
      SQ_IDLE: begin
        if (start) begin
          w_next = (out_len_bytes == '0) ? SQ_DONE : SQ_WAIT_BLOCK;
        end
      end
      SQ_WAIT_BLOCK: begin
        block_ready = 1'b1;
        if (block_valid) w_next = SQ_EMIT;
      end
      SQ_EMIT: begin
        dout_valid = 1'b1;
        if (dout_ready) begin
          if (w_last)            w_next = SQ_DONE;
          else if (w_idx_at_end) w_next = SQ_REQUEST;
        end
      end
      SQ_REQUEST: begin
        perm_request = 1'b1;
        w_next       = SQ_WAIT_BLOCK;
      end
      SQ_DONE: begin
        done   = 1'b1;
        w_next = SQ_IDLE;
      end
      default: w_next = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SQ_IDLE;
      r_remaining <= '0;
      r_word_idx  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        SQ_IDLE: begin
          if (start) begin
            r_remaining <= out_len_bytes;
            r_word_idx  <= '0;
          end
        end
        SQ_WAIT_BLOCK: begin
          if (block_valid) r_word_idx <= '0;
        end
        SQ_EMIT: begin
          if (w_accept) begin
            r_remaining <= r_remaining - LEN_WIDTH'(w_vbytes);
            // On the block's final lane the index is reset when the next
            // block is accepted, so it simply holds here.
            if (!w_last && !w_idx_at_end) r_word_idx <= r_word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign word_idx         = r_word_idx;
  assign dout             = w_dout;
  assign dout_valid_bytes = w_vbytes;
  assign dout_last        = w_last;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_squeeze_output_unit.sv
module tb_squeeze_output_unit;
  import keccak_pkg::*;

  localparam int RATE = 21;
  localparam int LW   = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [LW-1:0] out_len_bytes;
  logic          block_valid;
  logic          block_ready;
  logic [4:0]    word_idx;
  logic [63:0]   state_word;
  logic          perm_request;
  logic [63:0]   dout;
  logic [3:0]    dout_valid_bytes;
  logic          dout_last;
  logic          dout_valid;
  logic          dout_ready;
  logic          done;
  logic [2:0]    dbg_state;

  squeeze_output_unit #(.RATE_WORDS(RATE), .LEN_WIDTH(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .out_len_bytes    (out_len_bytes),
    .block_valid      (block_valid),
    .block_ready      (block_ready),
    .word_idx         (word_idx),
    .state_word       (state_word),
    .perm_request     (perm_request),
    .dout             (dout),
    .dout_valid_bytes (dout_valid_bytes),
    .dout_last        (dout_last),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .done             (done),
    .dbg_state        (dbg_state)
  );

  // Model of the Keccak state: the rate lanes of the current block.
  logic [63:0] blk_data [RATE];
  assign state_word = (word_idx < 5'(RATE)) ? blk_data[word_idx] : 64'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: keep the k most-significant bytes of a lane, clear the rest.
  function automatic logic [63:0] keep_top(input logic [63:0] v, input int k);
    logic [63:0] r;
    int sh;
    if (k >= 8) return v;
    sh = 64 - 8 * k;
    r = (v >> sh) << sh;
    return r;
  endfunction

  task automatic new_block(input bit fixed_w1);
    for (int i = 0; i < RATE; i++) blk_data[i] = {$urandom(), $urandom()};
    if (fixed_w1) blk_data[1] = 64'h0123456789ABCDEF;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_block_ready"}, 64'(block_ready), 64'd0);
    chk({tag, "_perm_request"}, 64'(perm_request), 64'd0);
    chk({tag, "_dout"}, dout, 64'd0);
    chk({tag, "_vbytes"}, 64'(dout_valid_bytes), 64'd0);
    chk({tag, "_last"}, 64'(dout_last), 64'd0);
    chk({tag, "_dout_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_word_idx"}, 64'(word_idx), 64'd0);
  endtask

  // Check the word on offer against the reference for global word n.
  task automatic check_word(input int len, input int n, input int i);
    int rem, k;
    rem = len - 8 * n;
    k   = (rem > 8) ? 8 : rem;
    chk("emit_valid", 64'(dout_valid), 64'd1);
    chk("emit_idx", 64'(word_idx), 64'(i));
    chk("emit_vbytes", 64'(dout_valid_bytes), 64'(k));
    chk("emit_last", 64'(dout_last), 64'(rem <= 8));
    chk("emit_dout", dout, keep_top(blk_data[i], k));
    chk("emit_no_preq", 64'(perm_request), 64'd0);
    chk("emit_no_done", 64'(done), 64'd0);
  endtask

  // One complete squeeze, starting and ending at a negedge with the DUT idle.
  task automatic run_squeeze(input int len, input int stall_word, input int stall_n,
                             input bit rand_bp, input bit fixed_w1);
    int nwords, sent, waits, stalls;
    nwords = (len + 7) / 8;
    sent   = 0;
    start = 1'b1;
    out_len_bytes = LW'(len);
    dout_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_dout_valid", 64'(dout_valid), 64'd0);
      chk("zero_block_ready", 64'(block_ready), 64'd0);
      @(negedge clk);
      check_quiet("zero_after");
      return;
    end
    while (sent < nwords) begin
      chk("wait_block_ready", 64'(block_ready), 64'd1);
      chk("wait_dout_valid", 64'(dout_valid), 64'd0);
      waits = $urandom_range(0, 2);
      for (int c = 0; c < waits; c++) begin
        @(negedge clk);
        chk("wait_hold_ready", 64'(block_ready), 64'd1);
      end
      new_block(fixed_w1);
      block_valid = 1'b1;
      @(negedge clk);
      block_valid = 1'b0;
      chk("accept_block_ready_low", 64'(block_ready), 64'd0);
      for (int i = 0; i < RATE && sent < nwords; i++) begin
        stalls = (sent == stall_word) ? stall_n : (rand_bp ? $urandom_range(0, 2) : 0);
        for (int s = 0; s < stalls; s++) begin
          dout_ready = 1'b0;
          check_word(len, sent, i);
          @(negedge clk);
        end
        dout_ready = 1'b1;
        check_word(len, sent, i);
        if (fixed_w1 && sent == 1)
          chk("fixed_w1_dout", dout, 64'h0123456789000000);
        @(negedge clk);
        sent++;
      end
      if (sent < nwords) begin
        chk("request_pulse", 64'(perm_request), 64'd1);
        chk("request_no_valid", 64'(dout_valid), 64'd0);
        @(negedge clk);
        chk("request_single", 64'(perm_request), 64'd0);
      end
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_no_preq", 64'(perm_request), 64'd0);
    chk("done_no_valid", 64'(dout_valid), 64'd0);
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("back_idle_ready", 64'(block_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_len_bytes = '0;
    block_valid = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < RATE; i++) blk_data[i] = 64'h0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    chk("reset_state", 64'(dbg_state), 64'(SQ_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // Directed cases.
    run_squeeze(32, -1, 0, 1'b0, 1'b0);
    run_squeeze(13, -1, 0, 1'b0, 1'b1);
    run_squeeze(200, -1, 0, 1'b0, 1'b0);
    run_squeeze(0, -1, 0, 1'b0, 1'b0);
    run_squeeze(64, 5, 3, 1'b0, 1'b0);
    run_squeeze(1, -1, 0, 1'b0, 1'b0);
    run_squeeze(8 * RATE, -1, 0, 1'b0, 1'b0);
    run_squeeze(8 * RATE + 1, -1, 0, 1'b0, 1'b0);

    // start ignored outside IDLE: pulse it while waiting for a block.
    start = 1'b1;
    out_len_bytes = 32'd8;
    @(negedge clk);
    out_len_bytes = 32'd99;
    chk("ign_wait", 64'(block_ready), 64'd1);
    @(negedge clk);
    start = 1'b0;
    new_block(1'b0);
    block_valid = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
    check_word(8, 0, 0);
    @(negedge clk);
    chk("ign_done", 64'(done), 64'd1);
    @(negedge clk);

    // Reset in EMIT at word 2.
    start = 1'b1;
    out_len_bytes = 32'd64;
    @(negedge clk);
    start = 1'b0;
    new_block(1'b0);
    block_valid = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_idx", 64'(word_idx), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("mid_rst");
    chk("mid_rst_state", 64'(dbg_state), 64'(SQ_IDLE));
    @(negedge clk);
    chk("post_rst_no_done", 64'(done), 64'd0);
    run_squeeze(16, -1, 0, 1'b0, 1'b0);

    // Randomized lengths with random backpressure.
    for (int t = 0; t < 8; t++) begin
      run_squeeze($urandom_range(1, 400), $urandom_range(0, 40), $urandom_range(1, 3),
                  1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
